// File: rtl/sram_pixel_server_pkg.sv
// Shared frame/SRAM parameters and state encoding
// for the pixel server.
package sram_pixel_server_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int ADDR_W    = 20;
  localparam int BASE_ADDR = 0;
  localparam int READ_WAIT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    READ = ST_READ,
    RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/pixel_addr_gen.sv
// Frame bounds check and linear SRAM word address
// for an (X,Y) pixel coordinate.
module pixel_addr_gen #(
  parameter int H_RES     = sram_pixel_server_pkg::H_RES,
  parameter int V_RES     = sram_pixel_server_pkg::V_RES,
  parameter int ADDR_W    = sram_pixel_server_pkg::ADDR_W,
  parameter int BASE_ADDR = sram_pixel_server_pkg::BASE_ADDR
) (
  input  logic [12:0]       iX,
  input  logic [12:0]       iY,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  import sram_pixel_server_pkg::*;

  always_comb begin
    in_range = (32'(iX) < 32'(H_RES)) &&
               (32'(iY) < 32'(V_RES));
    addr = ADDR_W'(32'(BASE_ADDR) +
                   32'(iY) * 32'(H_RES) +
                   32'(iX));
  end

endmodule

// File: rtl/sram_pixel_server.sv
// Pixel-coordinate read responder: async SRAM read
// with a one-entry last-pixel cache.
module sram_pixel_server #(
  parameter int H_RES     = sram_pixel_server_pkg::H_RES,
  parameter int V_RES     = sram_pixel_server_pkg::V_RES,
  parameter int ADDR_W    = sram_pixel_server_pkg::ADDR_W,
  parameter int BASE_ADDR = sram_pixel_server_pkg::BASE_ADDR,
  parameter int READ_WAIT = sram_pixel_server_pkg::READ_WAIT
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq,
  input  logic [12:0]       iX,
  input  logic [12:0]       iY,
  input  logic              iFlush,
  output logic              oReady,
  output logic              oValid,
  output logic [9:0]        oReading,
  output logic              oOOR,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_UB_N,
  output logic              oSRAM_LB_N,
  input  logic [15:0]       iSRAM_DQ
);
  import sram_pixel_server_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              oor_q, oor_d;
  logic [9:0]        reading_q, reading_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              strobe_q, strobe_d;
  logic              cvld_q, cvld_d;
  logic [12:0]       cx_q, cx_d;
  logic [12:0]       cy_q, cy_d;
  logic [9:0]        cpix_q, cpix_d;
  logic [12:0]       rx_q, rx_d;
  logic [12:0]       ry_q, ry_d;

  logic              in_range;
  logic [ADDR_W-1:0] lin_addr;
  logic              hit;
  logic              unused_dq;

  pixel_addr_gen #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr (
    .iX       (iX),
    .iY       (iY),
    .in_range (in_range),
    .addr     (lin_addr)
  );

  assign unused_dq = ^iSRAM_DQ[15:10];
  assign hit = cvld_q && !iFlush &&
               (iX == cx_q) && (iY == cy_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    oor_d     = oor_q;
    reading_d = reading_q;
    addr_d    = addr_q;
    strobe_d  = strobe_q;
    cvld_d    = cvld_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    cpix_d    = cpix_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    if (iFlush) cvld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iReq) begin
          rx_d = iX;
          ry_d = iY;
          if (!in_range) begin
            state_d   = RESP;
            valid_d   = 1'b1;
            oor_d     = 1'b1;
            reading_d = 10'd0;
          end else if (hit) begin
            state_d   = RESP;
            valid_d   = 1'b1;
            oor_d     = 1'b0;
            reading_d = cpix_q;
          end else begin
            state_d  = READ;
            addr_d   = lin_addr;
            strobe_d = 1'b1;
            cnt_d    = 3'(READ_WAIT);
          end
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          // Refill wins over a same-edge flush.
          state_d   = RESP;
          strobe_d  = 1'b0;
          valid_d   = 1'b1;
          oor_d     = 1'b0;
          reading_d = iSRAM_DQ[9:0];
          cpix_d    = iSRAM_DQ[9:0];
          cx_d      = rx_q;
          cy_d      = ry_q;
          cvld_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      oor_q     <= 1'b0;
      reading_q <= 10'd0;
      addr_q    <= '0;
      strobe_q  <= 1'b0;
      cvld_q    <= 1'b0;
      cx_q      <= 13'd0;
      cy_q      <= 13'd0;
      cpix_q    <= 10'd0;
      rx_q      <= 13'd0;
      ry_q      <= 13'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      oor_q     <= oor_d;
      reading_q <= reading_d;
      addr_q    <= addr_d;
      strobe_q  <= strobe_d;
      cvld_q    <= cvld_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cpix_q    <= cpix_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
    end
  end

  assign oReady     = ready_q;
  assign oValid     = valid_q;
  assign oReading   = reading_q;
  assign oOOR       = oor_q;
  assign oSRAM_ADDR = addr_q;
  assign oSRAM_CE_N = ~strobe_q;
  assign oSRAM_OE_N = ~strobe_q;
  assign oSRAM_UB_N = ~strobe_q;
  assign oSRAM_LB_N = ~strobe_q;
  assign oSRAM_WE_N = 1'b1;

endmodule

// File: tb/tb_sram_pixel_server.sv
// Bench for sram_pixel_server: directed table, random
// traffic vs. a cache model, and corner sequences.
module tb_sram_pixel_server;

  logic        clk, rst, req, flush;
  logic [12:0] x, y;
  logic        ready, valid, oor;
  logic [9:0]  reading;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] dq;

  logic        z_req;
  logic [12:0] z_x, z_y;
  logic        z_ready, z_valid, z_oor;
  logic [9:0]  z_reading;
  logic [19:0] z_addr;
  logic        z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n;
  logic [15:0] z_dq;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] sram_fn(input logic [19:0] a);
    logic [31:0] t;
    if (a == 20'd1283) return 16'hFDA5;
    t = {12'd0, a} * 32'd40503;
    return t[15:0] ^ 16'hC3A5;
  endfunction

  function automatic int pix_of(input int px, input int py);
    logic [15:0] w;
    w = sram_fn(20'(py * 640 + px));
    return int'(w[9:0]);
  endfunction

  assign dq   = sram_fn(addr);
  assign z_dq = sram_fn(z_addr);

  sram_pixel_server dut (
    .iCLK(clk), .iRST(rst), .iReq(req), .iX(x), .iY(y),
    .iFlush(flush), .oReady(ready), .oValid(valid),
    .oReading(reading), .oOOR(oor), .oSRAM_ADDR(addr),
    .oSRAM_CE_N(ce_n), .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n),
    .oSRAM_UB_N(ub_n), .oSRAM_LB_N(lb_n), .iSRAM_DQ(dq)
  );

  sram_pixel_server #(.READ_WAIT(0)) dut0 (
    .iCLK(clk), .iRST(rst), .iReq(z_req), .iX(z_x), .iY(z_y),
    .iFlush(1'b0), .oReady(z_ready), .oValid(z_valid),
    .oReading(z_reading), .oOOR(z_oor), .oSRAM_ADDR(z_addr),
    .oSRAM_CE_N(z_ce_n), .oSRAM_OE_N(z_oe_n), .oSRAM_WE_N(z_we_n),
    .oSRAM_UB_N(z_ub_n), .oSRAM_LB_N(z_lb_n), .iSRAM_DQ(z_dq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Issue one request, return response latency, data,
  // strobe-cycle count and strobe/address anomalies.
  task automatic do_req(input int rx, input int ry, input logic fl,
                        input int fl_read, output int lat,
                        output int rd, output int ro,
                        output int nstb, output int bad);
    logic [19:0] ea;
    ea = 20'(ry * 640 + rx);
    req = 1'b1; x = 13'(rx); y = 13'(ry); flush = fl;
    for (int i = 0; i < 50 && !ready; i++) tick();
    if (!ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: ready stuck low");
    end
    tick();
    req = 1'b0; flush = 1'b0;
    x = 13'($urandom); y = 13'($urandom);
    lat = -1; rd = -1; ro = -1; nstb = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      flush = (k == fl_read);
      if (valid) begin
        lat = k; rd = int'(reading); ro = int'(oor);
        break;
      end
      if (!ce_n || !oe_n || !ub_n || !lb_n) begin
        nstb++;
        if (ce_n || oe_n || ub_n || lb_n || addr != ea) bad++;
      end
      tick();
    end
    flush = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL valid_timeout: no oValid for (%0d,%0d)", rx, ry);
    end
  endtask

  typedef struct {
    int   x, y;
    logic fl;
    int   lat, rd, oor, stb;
  } vec_t;

  vec_t tbl[9];

  int lat, rd, ro, nstb, bad, nv;
  int mx, my, mpix;
  logic mvld;
  int ex_lat, ex_rd, ex_oor, ex_stb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; x = '0; y = '0;
    z_req = 1'b0; z_x = '0; z_y = '0;
    tick(); tick();
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_reading", int'(reading), 0);
    check("rst_oor", int'(oor), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_strobes", int'({ce_n, oe_n, ub_n, lb_n, we_n}), 5'h1F);
    check("rst_z_ready", int'(z_ready), 1);
    rst = 1'b0;
    tick();

    tbl[0] = '{3, 2, 1'b0, 4, 'h1A5, 0, 3};
    tbl[1] = '{3, 2, 1'b0, 1, 'h1A5, 0, 0};
    tbl[2] = '{640, 0, 1'b0, 1, 0, 1, 0};
    tbl[3] = '{0, 480, 1'b0, 1, 0, 1, 0};
    tbl[4] = '{3, 2, 1'b0, 1, 'h1A5, 0, 0};
    tbl[5] = '{3, 2, 1'b1, 4, 'h1A5, 0, 3};
    tbl[6] = '{3, 2, 1'b0, 1, 'h1A5, 0, 0};
    tbl[7] = '{8191, 8191, 1'b0, 1, 0, 1, 0};
    tbl[8] = '{639, 479, 1'b0, 4, pix_of(639, 479), 0, 3};

    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].x, tbl[i].y, tbl[i].fl, 0, lat, rd, ro, nstb, bad);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      check($sformatf("tbl%0d_oor", i), ro, tbl[i].oor);
      check($sformatf("tbl%0d_stb", i), nstb, tbl[i].stb);
      check($sformatf("tbl%0d_bad", i), bad, 0);
      tick();
      check($sformatf("tbl%0d_pulse", i), int'(valid), 0);
      check($sformatf("tbl%0d_hold", i), int'(reading), tbl[i].rd);
    end
    check("we_n_high", int'(we_n), 1);

    // Reference cache model continues from the last table entry.
    mvld = 1'b1; mx = 639; my = 479; mpix = pix_of(639, 479);
    for (int i = 0; i < 150; i++) begin
      int sel, rx, ry;
      logic fl;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        rx = mx; ry = my;
      end else if (sel == 1) begin
        rx = int'($urandom_range(0, 8191));
        ry = int'($urandom_range(400, 8191));
      end else begin
        rx = int'($urandom_range(0, 15));
        ry = int'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 7) == 0);
      if (rx >= 640 || ry >= 480) begin
        ex_lat = 1; ex_rd = 0; ex_oor = 1; ex_stb = 0;
        if (fl) mvld = 1'b0;
      end else if (mvld && !fl && rx == mx && ry == my) begin
        ex_lat = 1; ex_rd = mpix; ex_oor = 0; ex_stb = 0;
      end else begin
        ex_lat = 4; ex_rd = pix_of(rx, ry); ex_oor = 0; ex_stb = 3;
        mvld = 1'b1; mx = rx; my = ry; mpix = ex_rd;
      end
      do_req(rx, ry, fl, 0, lat, rd, ro, nstb, bad);
      check($sformatf("rnd%0d_lat", i), lat, ex_lat);
      check($sformatf("rnd%0d_rd", i), rd, ex_rd);
      check($sformatf("rnd%0d_oor", i), ro, ex_oor);
      check($sformatf("rnd%0d_stb", i), nstb, ex_stb);
      check($sformatf("rnd%0d_bad", i), bad, 0);
    end

    // Flush during READ: the read still refills the cache.
    do_req(5, 5, 1'b1, 1, lat, rd, ro, nstb, bad);
    check("flrd_lat", lat, 4);
    check("flrd_rd", rd, pix_of(5, 5));
    do_req(5, 5, 1'b0, 0, lat, rd, ro, nstb, bad);
    check("flrd_hit_lat", lat, 1);
    check("flrd_hit_rd", rd, pix_of(5, 5));

    // Flush while idle invalidates the cache.
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    do_req(5, 5, 1'b0, 0, lat, rd, ro, nstb, bad);
    check("flidle_lat", lat, 4);
    check("flidle_stb", nstb, 3);

    // Back-to-back hits with iReq held: one response per 2 cycles.
    req = 1'b1; x = 13'd5; y = 13'd5;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid) nv++;
    end
    req = 1'b0;
    check("b2b_hits", nv, 4);
    tick();

    // Reset during the second READ cycle.
    req = 1'b1; x = 13'd3; y = 13'd2; flush = 1'b1;
    for (int i = 0; i < 50 && !ready; i++) tick();
    tick();
    req = 1'b0; flush = 1'b0;
    tick();
    check("midrd_strobe_on", int'(ce_n), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrd_ce_off", int'(ce_n), 1);
    check("midrd_oe_off", int'(oe_n), 1);
    check("midrd_ready", int'(ready), 1);
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) nv++;
      tick();
    end
    check("midrd_no_valid", nv, 0);
    do_req(3, 2, 1'b0, 0, lat, rd, ro, nstb, bad);
    check("midrd_miss_lat", lat, 4);
    check("midrd_miss_rd", rd, 'h1A5);
    check("midrd_miss_stb", nstb, 3);

    // READ_WAIT=0 instance, iReq held high, alternating corners.
    z_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int zx, zy, zl, zs, zb, zr;
      zx = (i % 2 == 0) ? 0 : 639;
      zy = (i % 2 == 0) ? 0 : 479;
      z_x = 13'(zx); z_y = 13'(zy);
      for (int j = 0; j < 20 && !z_ready; j++) tick();
      tick();
      zl = -1; zs = 0; zb = 0; zr = -1;
      for (int k = 1; k <= 10; k++) begin
        if (z_valid) begin
          zl = k; zr = int'(z_reading);
          break;
        end
        if (!z_ce_n) begin
          zs++;
          if (int'(z_addr) != zy * 640 + zx) zb++;
        end
        tick();
      end
      check($sformatf("alt%0d_lat", i), zl, 2);
      check($sformatf("alt%0d_stb", i), zs, 1);
      check($sformatf("alt%0d_addr", i), zb, 0);
      check($sformatf("alt%0d_rd", i), zr, pix_of(zx, zy));
      check($sformatf("alt%0d_ready", i), int'(z_ready), 0);
    end
    z_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
